seq_mac_array: RTL

SEQ_MAC_ARRAY -- requirements
Module: seq_mac_array

---
 rtl/seq_mac_pkg.sv | 22 ++
 rtl/seq_mac_lane.sv | 68 ++++++
 rtl/seq_mac_array.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/seq_mac_pkg.sv
// seq_mac_pkg: shared FSM states, sizing helpers and saturation for seq_mac_array
package seq_mac_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam int SAT_W = 128;
  function automatic int digits_f(input int mw, input int p);
    return mw / p;
  endfunction
  // Accumulator width: wide enough for c plus K full-width products, plus a sign bit.
  function automatic int aw_f(input int acc_w, input int mw, input int k);
    int pw;
    pw = 2 * mw + $clog2(k);
    return (acc_w > pw ? acc_w : pw) + 1;
  endfunction
  // Clamp a signed value to the w-bit two's-complement range.
  function automatic logic [SAT_W-1:0] sat_f(input logic signed [SAT_W-1:0] v, input int w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (128'sd1 <<< (w - 1)) - 128'sd1;
    lo = -hi - 128'sd1;
    return v > hi ? hi : (v < lo ? lo : v);
  endfunction
endpackage

// File: rtl/seq_mac_lane.sv
// seq_mac_lane: one output channel -- K digit multipliers, adder tree, shifter, accumulator
// Ports: i_clr abort, i_load init acc from i_c, i_add accumulate digit pair (i_i,i_j),
//        i_out form o_res (wrap or saturate per i_sat), operands i_row/i_col latched by the controller.
module seq_mac_lane
  import seq_mac_pkg::*;
#(
  parameter int K = 2,
  parameter int MAX_WIDTH = 16,
  parameter int P = 2,
  parameter int ACC_WIDTH = 32,
  parameter int AW = 34,
  parameter int CW = 5
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   i_clr,
  input  logic                   i_load,
  input  logic                   i_add,
  input  logic                   i_out,
  input  logic                   i_sgn,
  input  logic                   i_sat,
  input  logic [CW-1:0]          i_d,
  input  logic [CW-1:0]          i_i,
  input  logic [CW-1:0]          i_j,
  input  logic [K*MAX_WIDTH-1:0] i_row,
  input  logic [K*MAX_WIDTH-1:0] i_col,
  input  logic [ACC_WIDTH-1:0]   i_c,
  output logic [ACC_WIDTH-1:0]   o_res
);
  localparam int TW = 2 * P + 3 + $clog2(K);
  logic [CW-1:0]         w_dm1;
  logic signed [P:0]     w_a;
  logic signed [P:0]     w_b;
  logic signed [2*P+1:0] w_p;
  logic signed [TW-1:0]  w_term;
  logic signed [AW-1:0]  w_sh;
  logic signed [AW-1:0]  r_acc;
  logic [ACC_WIDTH-1:0]  r_res;
  assign w_dm1 = i_d - CW'(1);
  // Each digit gets one extension bit: only the top digit of a signed operand carries sign.
  always_comb begin
    w_term = '0;
    w_a = '0;
    w_b = '0;
    w_p = '0;
    for (int k = 0; k < K; k++) begin
      w_a = {i_sgn & (i_i == w_dm1) & i_row[k*MAX_WIDTH + int'(i_i)*P + P-1], i_row[k*MAX_WIDTH + int'(i_i)*P +: P]};
      w_b = {i_sgn & (i_j == w_dm1) & i_col[k*MAX_WIDTH + int'(i_j)*P + P-1], i_col[k*MAX_WIDTH + int'(i_j)*P +: P]};
      w_p = w_a * w_b;
      w_term = w_term + TW'(w_p);
    end
  end
  assign w_sh = AW'(w_term) <<< (P * (int'(i_i) + int'(i_j)));
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_acc <= '0;
      r_res <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
      r_res <= '0;
    end else begin
      if (i_load) r_acc <= AW'($signed(i_c));
      else if (i_add) r_acc <= r_acc + w_sh;
      if (i_out) r_res <= i_sat ? ACC_WIDTH'(sat_f(SAT_W'(r_acc), ACC_WIDTH)) : r_acc[ACC_WIDTH-1:0];
    end
  end
  assign o_res = r_res;
endmodule

// File: rtl/seq_mac_array.sv
// seq_mac_array: digit-serial multiply-accumulate of one row vector against N column vectors
// Ports: clk_i/rst_ni clock and async active-low reset, clear_i sync abort,
//        row_i/col_i/c_i operands and accumulate-in, prec_i precision in P-bit digits,
//        signed_i/sat_i operand mode and result saturation, valid_i/ready_o input handshake,
//        res_o/valid_o/ready_i result and output handshake.
module seq_mac_array
  import seq_mac_pkg::*;
#(
  parameter int K = 2,
  parameter int N = 4,
  parameter int MAX_WIDTH = 16,
  parameter int P = 2,
  parameter int ACC_WIDTH = 32
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           clear_i,
  input  logic [K*MAX_WIDTH-1:0]         row_i,
  input  logic [N*K*MAX_WIDTH-1:0]       col_i,
  input  logic [N*ACC_WIDTH-1:0]         c_i,
  input  logic [$clog2(MAX_WIDTH/P):0]   prec_i,
  input  logic                           signed_i,
  input  logic                           sat_i,
  input  logic                           valid_i,
  output logic                           ready_o,
  output logic [N*ACC_WIDTH-1:0]         res_o,
  output logic                           valid_o,
  input  logic                           ready_i
);
  localparam int DMAX = digits_f(MAX_WIDTH, P);
  localparam int PW = $clog2(DMAX) + 1;
  localparam int CW = PW + 1;
  localparam int AW = aw_f(ACC_WIDTH, MAX_WIDTH, K);
  state_e                   r_state;
  state_e                   w_next;
  logic [K*MAX_WIDTH-1:0]   r_row;
  logic [N*K*MAX_WIDTH-1:0] r_col;
  logic [CW-1:0]            r_d;
  logic [CW-1:0]            r_i;
  logic [CW-1:0]            r_j;
  logic [CW-1:0]            r_s;
  logic                     r_sgn;
  logic                     r_sat;
  logic                     r_drain;
  logic [CW-1:0]            w_d;
  logic [CW-1:0]            w_ihi;
  logic [CW-1:0]            w_ilo;
  logic [CW-1:0]            w_s1;
  logic [CW-1:0]            w_ni;
  logic [CW-1:0]            w_ns;
  logic                     w_step;
  logic                     w_last;
  logic                     w_acc;
  logic                     w_add;
  logic                     w_out;
  assign ready_o = (r_state == IDLE) | ((r_state == DONE) & ready_i);
  assign valid_o = r_state == DONE;
  assign w_acc = valid_i & ready_o & ~clear_i;
  assign w_add = (r_state == RUN) & ~r_drain;
  // One extra RUN cycle after the last pair lets the final sum settle before the result is formed.
  assign w_out = (r_state == RUN) & r_drain;
  assign w_d = (prec_i == '0 || prec_i > PW'(DMAX)) ? CW'(DMAX) : CW'(prec_i);
  // Walk anti-diagonals s=i+j; i runs from max(0,s-(D-1)) to min(s,D-1).
  assign w_s1 = r_s + CW'(1);
  assign w_ihi = (r_s < r_d) ? r_s : r_d - CW'(1);
  assign w_ilo = (w_s1 >= r_d) ? w_s1 - r_d + CW'(1) : '0;
  assign w_step = r_i != w_ihi;
  assign w_ni = w_step ? r_i + CW'(1) : w_ilo;
  assign w_ns = w_step ? r_s : w_s1;
  assign w_last = r_s == (r_d << 1) - CW'(2);
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = w_acc ? RUN : IDLE;
      RUN: w_next = r_drain ? DONE : RUN;
      DONE: w_next = ready_i ? (w_acc ? RUN : IDLE) : DONE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_row <= '0;
      r_col <= '0;
      r_d <= '0;
      r_i <= '0;
      r_j <= '0;
      r_s <= '0;
      r_sgn <= 1'b0;
      r_sat <= 1'b0;
      r_drain <= 1'b0;
    end else if (clear_i) begin
      r_state <= IDLE;
      r_i <= '0;
      r_j <= '0;
      r_s <= '0;
      r_drain <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        r_row <= row_i;
        r_col <= col_i;
        r_d <= w_d;
        r_sgn <= signed_i;
        r_sat <= sat_i;
        r_i <= '0;
        r_j <= '0;
        r_s <= '0;
        r_drain <= 1'b0;
      end else if (w_add) begin
        if (w_last) r_drain <= 1'b1;
        else begin
          r_i <= w_ni;
          r_s <= w_ns;
          r_j <= w_ns - w_ni;
        end
      end
    end
  end
  for (genvar n = 0; n < N; n++) begin : g_lane
    seq_mac_lane #(
      .K(K), .MAX_WIDTH(MAX_WIDTH), .P(P), .ACC_WIDTH(ACC_WIDTH), .AW(AW), .CW(CW)
    ) u_lane (
      .clk_i(clk_i),
      .rst_ni(rst_ni),
      .i_clr(clear_i),
      .i_load(w_acc),
      .i_add(w_add),
      .i_out(w_out),
      .i_sgn(r_sgn),
      .i_sat(r_sat),
      .i_d(r_d),
      .i_i(r_i),
      .i_j(r_j),
      .i_row(r_row),
      .i_col(r_col[n*K*MAX_WIDTH +: K*MAX_WIDTH]),
      .i_c(c_i[n*ACC_WIDTH +: ACC_WIDTH]),
      .o_res(res_o[n*ACC_WIDTH +: ACC_WIDTH])
    );
  end
endmodule
